// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch slice.
package fetch_pkg;

    localparam int INSTR_W = 32;
    localparam int PC_W    = 32;
    localparam int PC_STEP = 4;

    localparam logic [PC_W-1:0] DEFAULT_RESET_PC = 32'h0;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetched instructions with PC, plus single-cycle flush.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  fetch_entry_t             push_data,
    input  logic                     pop,
    output fetch_entry_t             head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    fetch_entry_t     mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [AW:0]      count_q;

    // Storage is cleared on reset so the head reads zero before the first push.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_comb begin
        head  = mem[rd_ptr];
        count = count_q;
        full  = (count_q == (AW+1)'(DEPTH));
        empty = (count_q == '0);
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC sequencing, one-cycle external memory read, and an
// instruction queue with redirect flush. WIDTH is expected to be at most PC_W.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter int               DEPTH    = 4,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(DEFAULT_RESET_PC)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               PCsrc,
    input  logic [WIDTH-1:0]   branch_pc,
    input  logic [WIDTH-1:0]   ImmOp,
    output logic               imem_en,
    output logic [WIDTH-1:0]   imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr,
    output logic [WIDTH-1:0]   instr_pc,
    output logic               instr_valid,
    input  logic               instr_ready
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] inflight_pc_q;
    logic             inflight_q;
    logic [WIDTH-1:0] target;
    logic [CW:0]      occupancy;
    logic [CW-1:0]    q_count;
    logic             q_full;
    logic             q_empty;
    logic             push;
    logic             pop;
    fetch_entry_t     push_entry;
    fetch_entry_t     head;

    // In-flight requests reserve a queue slot so a response always has room.
    always_comb begin
        occupancy        = {1'b0, q_count} + (CW+1)'(inflight_q);
        target           = branch_pc + ImmOp;
        target[1:0]      = 2'b00;
        imem_en          = rst && !PCsrc && !q_full && (occupancy < (CW+1)'(DEPTH));
        push             = inflight_q && !PCsrc;
        pop              = !q_empty && instr_ready;
        push_entry.instr = imem_rdata;
        push_entry.pc    = PC_W'(inflight_pc_q);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else if (PCsrc) begin
            pc_q       <= target;
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= imem_en;
            if (imem_en) begin
                pc_q          <= pc_q + WIDTH'(PC_STEP);
                inflight_pc_q <= pc_q;
            end
        end
    end

    fetch_queue #(
        .DEPTH(DEPTH)
    ) u_queue (
        .clk       (clk),
        .rst       (rst),
        .flush     (PCsrc),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head      (head),
        .count     (q_count),
        .full      (q_full),
        .empty     (q_empty)
    );

    assign imem_addr   = pc_q;
    assign instr       = head.instr;
    assign instr_pc    = WIDTH'(head.pc);
    assign instr_valid = !q_empty;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a one-cycle registered instruction memory model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        PCsrc;
    logic [31:0] branch_pc;
    logic [31:0] ImmOp;
    logic        imem_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = '0;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;

    int n_assert = 0;
    int n_fail   = 0;

    fetch_unit #(
        .WIDTH   (32),
        .DEPTH   (4),
        .RESET_PC(32'h0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .PCsrc      (PCsrc),
        .branch_pc  (branch_pc),
        .ImmOp      (ImmOp),
        .imem_en    (imem_en),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .instr      (instr),
        .instr_pc   (instr_pc),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready)
    );

    always #5 clk = ~clk;

    // Memory contents: word at address A is A + 32'h1000_0000.
    always @(posedge clk) begin
        if (imem_en) imem_rdata <= imem_addr + 32'h1000_0000;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   issued;
        logic hold_bad;

        rst = 1'b0; PCsrc = 1'b0; branch_pc = '0; ImmOp = '0; instr_ready = 1'b1;

        // Reset state and streaming from RESET_PC
        cyc(); #1;
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_en",    32'(imem_en),     32'd0);
        chk("rst_instr", instr,            32'h0);
        chk("rst_pc",    instr_pc,         32'h0);
        cyc(); rst = 1'b1; #1;
        chk("a0_en",    32'(imem_en),     32'd1);
        chk("a0_addr",  imem_addr,        32'h0);
        chk("a0_valid", 32'(instr_valid), 32'd0);
        cyc(); #1;
        chk("a1_addr",  imem_addr,        32'h4);
        chk("a1_valid", 32'(instr_valid), 32'd0);
        cyc(); #1;
        chk("a2_valid", 32'(instr_valid), 32'd1);
        chk("a2_pc",    instr_pc,         32'h0);
        chk("a2_instr", instr,            32'h1000_0000);
        chk("a2_addr",  imem_addr,        32'h8);
        cyc(); #1;
        chk("a3_pc",    instr_pc,         32'h4);
        cyc(); #1;
        chk("a4_pc",    instr_pc,         32'h8);
        chk("a4_instr", instr,            32'h1000_0008);

        // Reset mid-stream, then backpressure with ready=0
        cyc(); rst = 1'b0; instr_ready = 1'b0; #1;
        chk("mr_valid", 32'(instr_valid), 32'd0);
        cyc(); rst = 1'b1;
        issued = 0; hold_bad = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (imem_en) issued++;
            if (i >= 2 && !(instr_valid === 1'b1 && instr_pc === 32'h0)) hold_bad = 1'b1;
            cyc();
        end
        chk("bp_issued", 32'(issued),   32'd4);
        chk("bp_hold",   32'(hold_bad), 32'd0);
        instr_ready = 1'b1; #1;
        chk("bp_en_full", 32'(imem_en),     32'd0);
        chk("dr0_valid",  32'(instr_valid), 32'd1);
        chk("dr0_pc",     instr_pc,         32'h0);
        cyc(); #1;
        chk("dr1_pc",     instr_pc,         32'h4);
        chk("dr1_addr",   imem_addr,        32'h10);
        cyc(); #1;
        chk("dr2_pc",     instr_pc,         32'h8);
        cyc(); #1;
        chk("dr3_pc",     instr_pc,         32'hC);
        cyc(); #1;
        chk("dr4_pc",     instr_pc,         32'h10);

        // Fill the queue, then assert reset asynchronously
        cyc(); instr_ready = 1'b0;
        repeat (6) cyc();
        #1;
        chk("fq_en",    32'(imem_en),     32'd0);
        chk("fq_valid", 32'(instr_valid), 32'd1);
        rst = 1'b0; #1;
        chk("ar_valid", 32'(instr_valid), 32'd0);
        chk("ar_en",    32'(imem_en),     32'd0);
        chk("ar_instr", instr,            32'h0);
        cyc(); rst = 1'b1; #1;
        chk("rr_en",    32'(imem_en),     32'd1);
        chk("rr_addr",  imem_addr,        32'h0);

        // Redirect while 0 and 4 are queued and 8 is in flight
        cyc();
        cyc(); #1;
        chk("r2_pc", instr_pc, 32'h0);
        cyc(); PCsrc = 1'b1; branch_pc = 32'h8; ImmOp = 32'h10; #1;
        chk("r3_en",    32'(imem_en),     32'd0);
        chk("r3_valid", 32'(instr_valid), 32'd1);
        cyc(); PCsrc = 1'b0; instr_ready = 1'b1; #1;
        chk("r4_valid", 32'(instr_valid), 32'd0);
        chk("r4_en",    32'(imem_en),     32'd1);
        chk("r4_addr",  imem_addr,        32'h18);
        cyc(); #1;
        chk("r5_valid", 32'(instr_valid), 32'd0);
        cyc(); #1;
        chk("r6_valid", 32'(instr_valid), 32'd1);
        chk("r6_pc",    instr_pc,         32'h18);
        chk("r6_instr", instr,            32'h1000_0018);
        cyc(); #1;
        chk("r7_pc",    instr_pc,         32'h1C);

        // Redirect coinciding with transfer of pc 4, misaligned target 0x13
        cyc(); rst = 1'b0; #1;
        cyc(); rst = 1'b1; #1;
        chk("s0_addr", imem_addr, 32'h0);
        cyc();
        cyc(); #1;
        chk("s2_pc", instr_pc, 32'h0);
        cyc(); PCsrc = 1'b1; branch_pc = 32'h10; ImmOp = 32'h3; #1;
        chk("s3_valid", 32'(instr_valid), 32'd1);
        chk("s3_pc",    instr_pc,         32'h4);
        cyc(); PCsrc = 1'b0; #1;
        chk("s4_valid", 32'(instr_valid), 32'd0);
        chk("s4_addr",  imem_addr,        32'h10);
        cyc(); #1;
        chk("s5_valid", 32'(instr_valid), 32'd0);
        cyc(); #1;
        chk("s6_pc",    instr_pc,         32'h10);
        cyc(); #1;
        chk("s7_pc",    instr_pc,         32'h14);

        // Redirect sum wraps to 0xFFFFFFFC, then sequential fetch wraps to 0
        cyc(); PCsrc = 1'b1; branch_pc = 32'hFFFF_FFFF; ImmOp = 32'hFFFF_FFFD; #1;
        chk("w0_en",    32'(imem_en), 32'd0);
        cyc(); PCsrc = 1'b0; #1;
        chk("w1_addr",  imem_addr,    32'hFFFF_FFFC);
        cyc(); #1;
        chk("w2_addr",  imem_addr,    32'h0);
        cyc(); #1;
        chk("w3_pc",    instr_pc,     32'hFFFF_FFFC);
        chk("w3_instr", instr,        32'h0FFF_FFFC);
        cyc(); #1;
        chk("w4_pc",    instr_pc,     32'h0);
        chk("w4_instr", instr,        32'h1000_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
